ball_motion: RTL and testbench

BALL_MOTION -- requirements
Module: ball_motion

---
 rtl/ball_pkg.sv | 26 ++
 rtl/ball_axis.sv | 53 +++++
 rtl/ball_motion.sv | 185 ++++++++++++++++++
 tb/tb_ball_motion.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared definitions for the ball motion block: FSM states and default
// playfield geometry / speed constants.
package ball_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_SCORED = 2'd2
  } ball_state_t;

  localparam int DEF_X_W         = 10;
  localparam int DEF_Y_W         = 10;
  localparam int DEF_SPD_W       = 4;
  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_BALL_SZ     = 8;
  localparam int DEF_INIT_SPD    = 2;
  localparam int DEF_MAX_SPD     = 8;
  localparam int DEF_HOLD_FRAMES = 60;

  // Top-left coordinate that centres a ball of side 'size' in 'extent'.
  function automatic int ball_centre(input int extent, input int size);
    return (extent - size) / 2;
  endfunction

endpackage

// File: rtl/ball_axis.sv
// One motion axis: steps a coordinate by a speed, flags limit crossings and
// clamps the result to [0, LIMIT].
module ball_axis #(
  parameter int POS_W  = 10,
  parameter int SPD_W  = 4,
  parameter int LIMIT  = 632,
  // STRICT=1 flags only a step beyond a limit; STRICT=0 also flags landing on it
  parameter bit STRICT = 1'b1
) (
  input  logic [POS_W-1:0] pos,
  input  logic [SPD_W-1:0] spd,
  input  logic             dir_pos,
  output logic [POS_W-1:0] pos_next,
  output logic             lim_low,
  output logic             lim_high
);

  localparam logic [POS_W:0] LIM = (POS_W+1)'(LIMIT);

  logic [POS_W:0] step;
  logic           under;
  logic           over;
  logic           touch_low;
  logic           touch_high;

  always_comb begin
    step = '0;
    if (dir_pos) begin
      step = {1'b0, pos} + (POS_W+1)'(spd);
    end else begin
      step = {1'b0, pos} - (POS_W+1)'(spd);
    end
  end

  // The extra top bit of a decreasing step is the borrow, i.e. result < 0.
  assign under      = !dir_pos && step[POS_W];
  assign over       = dir_pos && (step > LIM);
  assign touch_low  = under || (step == '0);
  assign touch_high = over || (step == LIM);

  assign lim_low  = STRICT ? under : touch_low;
  assign lim_high = STRICT ? over : touch_high;

  always_comb begin
    pos_next = step[POS_W-1:0];
    if (under) begin
      pos_next = '0;
    end else if (over) begin
      pos_next = LIM[POS_W-1:0];
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Pong ball controller: serve, per-frame motion with wall and paddle
// reflection, scoring and a post-point hold before re-centring.
module ball_motion
  import ball_pkg::*;
#(
  parameter int X_W         = DEF_X_W,
  parameter int Y_W         = DEF_Y_W,
  parameter int SPD_W       = DEF_SPD_W,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int BALL_SZ     = DEF_BALL_SZ,
  parameter int INIT_SPD    = DEF_INIT_SPD,
  parameter int MAX_SPD     = DEF_MAX_SPD,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           serve,
  input  logic           paddle_hit_l,
  input  logic           paddle_hit_r,
  output logic [X_W-1:0] ball_x,
  output logic [Y_W-1:0] ball_y,
  output logic           point_l,
  output logic           point_r,
  output logic           in_play
);

  localparam logic [X_W-1:0]   XC         = X_W'(ball_centre(SCREEN_W, BALL_SZ));
  localparam logic [Y_W-1:0]   YC         = Y_W'(ball_centre(SCREEN_H, BALL_SZ));
  localparam logic [SPD_W-1:0] INIT_S     = SPD_W'(INIT_SPD);
  localparam logic [SPD_W-1:0] MAX_S      = SPD_W'(MAX_SPD);
  localparam int               HOLD_W     = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  ball_state_t       state_reg;
  logic [X_W-1:0]    ball_x_reg;
  logic [Y_W-1:0]    ball_y_reg;
  logic [SPD_W-1:0]  x_spd_reg;
  logic              x_dir_reg;      // 1: moving right (+x)
  logic              y_dir_reg;      // 1: moving down (+y)
  logic              serve_dir_reg;  // direction of the next serve
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              point_l_reg;
  logic              point_r_reg;
  logic              in_play_reg;

  logic              x_hit_valid;
  logic              x_dir_next;
  logic [SPD_W-1:0]  x_spd_next;
  logic [X_W-1:0]    x_pos_next;
  logic              x_lim_low;
  logic              x_lim_high;
  logic [Y_W-1:0]    y_pos_next;
  logic              y_lim_low;
  logic              y_lim_high;
  logic              y_dir_next;

  // Only the paddle on the side the ball is heading towards can return it.
  assign x_hit_valid = x_dir_reg ? paddle_hit_r : paddle_hit_l;
  assign x_dir_next  = x_hit_valid ? ~x_dir_reg : x_dir_reg;

  always_comb begin
    x_spd_next = x_spd_reg;
    if (x_hit_valid) begin
      x_spd_next = (x_spd_reg >= MAX_S) ? MAX_S : x_spd_reg + SPD_W'(1);
    end
  end

  ball_axis #(
    .POS_W  (X_W),
    .SPD_W  (SPD_W),
    .LIMIT  (SCREEN_W - BALL_SZ),
    .STRICT (1'b1)
  ) u_x_axis (
    .pos      (ball_x_reg),
    .spd      (x_spd_next),
    .dir_pos  (x_dir_next),
    .pos_next (x_pos_next),
    .lim_low  (x_lim_low),
    .lim_high (x_lim_high)
  );

  // The y axis bounces on reaching a wall, so it also flags landing exactly on one.
  ball_axis #(
    .POS_W  (Y_W),
    .SPD_W  (SPD_W),
    .LIMIT  (SCREEN_H - BALL_SZ),
    .STRICT (1'b0)
  ) u_y_axis (
    .pos      (ball_y_reg),
    .spd      (INIT_S),
    .dir_pos  (y_dir_reg),
    .pos_next (y_pos_next),
    .lim_low  (y_lim_low),
    .lim_high (y_lim_high)
  );

  always_comb begin
    y_dir_next = y_dir_reg;
    if (y_lim_low) begin
      y_dir_next = 1'b1;
    end else if (y_lim_high) begin
      y_dir_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      ball_x_reg    <= XC;
      ball_y_reg    <= YC;
      x_spd_reg     <= INIT_S;
      x_dir_reg     <= 1'b1;
      y_dir_reg     <= 1'b1;
      serve_dir_reg <= 1'b1;
      hold_cnt_reg  <= '0;
      point_l_reg   <= 1'b0;
      point_r_reg   <= 1'b0;
      in_play_reg   <= 1'b0;
    end else begin
      point_l_reg <= 1'b0;
      point_r_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          ball_x_reg <= XC;
          ball_y_reg <= YC;
          if (serve) begin
            state_reg   <= ST_MOVING;
            in_play_reg <= 1'b1;
            x_spd_reg   <= INIT_S;
            x_dir_reg   <= serve_dir_reg;
            y_dir_reg   <= 1'b1;
          end
        end
        ST_MOVING: begin
          if (frame_tick) begin
            ball_x_reg <= x_pos_next;
            ball_y_reg <= y_pos_next;
            y_dir_reg  <= y_dir_next;
            x_spd_reg  <= x_spd_next;
            x_dir_reg  <= x_dir_next;
            // Ball left the field past a paddle: the opposite player scores.
            if (x_lim_low) begin
              point_r_reg   <= 1'b1;
              serve_dir_reg <= 1'b1;
              state_reg     <= ST_SCORED;
              in_play_reg   <= 1'b0;
              hold_cnt_reg  <= '0;
            end else if (x_lim_high) begin
              point_l_reg   <= 1'b1;
              serve_dir_reg <= 1'b0;
              state_reg     <= ST_SCORED;
              in_play_reg   <= 1'b0;
              hold_cnt_reg  <= '0;
            end
          end
        end
        ST_SCORED: begin
          if (frame_tick) begin
            if (hold_cnt_reg == HOLD_LAST) begin
              state_reg    <= ST_IDLE;
              hold_cnt_reg <= '0;
              ball_x_reg   <= XC;
              ball_y_reg   <= YC;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
            end
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          in_play_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ball_x  = ball_x_reg;
  assign ball_y  = ball_y_reg;
  assign point_l = point_l_reg;
  assign point_r = point_r_reg;
  assign in_play = in_play_reg;

endmodule

// File: tb/tb_ball_motion.sv
// Randomized and directed checks of ball_motion against a behavioural model
// of the ball (signed integer positions, +1/-1 directions).
module tb_ball_motion;

  localparam int SW    = 640;
  localparam int SH    = 480;
  localparam int BS    = 8;
  localparam int INIT  = 2;
  localparam int MAXS  = 8;
  localparam int HOLD  = 60;
  localparam int XC    = (SW - BS) / 2;
  localparam int YC    = (SH - BS) / 2;
  localparam int XMAX  = SW - BS;
  localparam int YMAX  = SH - BS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       serve = 1'b0;
  logic       paddle_hit_l = 1'b0;
  logic       paddle_hit_r = 1'b0;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       point_l;
  logic       point_r;
  logic       in_play;

  always #5 clk = ~clk;

  ball_motion #(
    .X_W(10), .Y_W(10), .SPD_W(4), .SCREEN_W(SW), .SCREEN_H(SH), .BALL_SZ(BS),
    .INIT_SPD(INIT), .MAX_SPD(MAXS), .HOLD_FRAMES(HOLD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .serve        (serve),
    .paddle_hit_l (paddle_hit_l),
    .paddle_hit_r (paddle_hit_r),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .point_l      (point_l),
    .point_r      (point_r),
    .in_play      (in_play)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_cycles = 0;
  int n_rally  = 0;

  // Model: mode 0 idle, 1 moving, 2 scored; directions are +1 / -1.
  int m_mode, m_x, m_y, m_xs, m_xdir, m_ydir, m_sdir, m_hold;
  bit m_pl, m_pr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, n_cycles);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_x = XC; m_y = YC; m_xs = INIT;
    m_xdir = 1; m_ydir = 1; m_sdir = 1; m_hold = 0;
    m_pl = 0; m_pr = 0;
  endtask

  task automatic model_step(input bit s, input bit t, input bit hl, input bit hr);
    int nx, ny;
    m_pl = 0;
    m_pr = 0;
    if (m_mode == 0) begin
      m_x = XC;
      m_y = YC;
      if (s) begin
        m_mode = 1; m_xs = INIT; m_xdir = m_sdir; m_ydir = 1;
      end
    end else if (m_mode == 1 && t) begin
      if ((m_xdir < 0 && hl) || (m_xdir > 0 && hr)) begin
        m_xdir = -m_xdir;
        m_xs = (m_xs + 1 > MAXS) ? MAXS : m_xs + 1;
      end
      nx = m_x + m_xdir * m_xs;
      ny = m_y + m_ydir * INIT;
      if (ny <= 0) begin
        ny = 0; m_ydir = 1;
      end else if (ny >= YMAX) begin
        ny = YMAX; m_ydir = -1;
      end
      m_y = ny;
      if (nx < 0) begin
        m_x = 0; m_pr = 1; m_sdir = 1; m_mode = 2; m_hold = 0;
      end else if (nx > XMAX) begin
        m_x = XMAX; m_pl = 1; m_sdir = -1; m_mode = 2; m_hold = 0;
      end else begin
        m_x = nx;
      end
    end else if (m_mode == 2 && t) begin
      m_hold++;
      if (m_hold == HOLD) begin
        m_mode = 0; m_hold = 0; m_x = XC; m_y = YC;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("ball_x", ball_x, m_x);
    check_eq("ball_y", ball_y, m_y);
    check_eq("point_l", point_l, m_pl);
    check_eq("point_r", point_r, m_pr);
    check_eq("in_play", in_play, (m_mode == 1));
  endtask

  task automatic run_cycle(input bit r, input bit s, input bit t, input bit hl, input bit hr);
    @(negedge clk);
    reset = r; serve = s; frame_tick = t; paddle_hit_l = hl; paddle_hit_r = hr;
    @(posedge clk);
    n_cycles++;
    if (reset) model_reset();
    else model_step(s, t, hl, hr);
    if (m_pl || m_pr) begin
      n_rally++;
      $display("rally %0d: point to %s at cycle %0d, ball (%0d,%0d)",
               n_rally, m_pl ? "left" : "right", n_cycles, m_x, m_y);
    end
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    run_cycle(1, 0, 0, 0, 0);
    run_cycle(0, 0, 1, 0, 0);
    check_eq("idle_x", ball_x, 316);
    check_eq("idle_y", ball_y, 236);
    check_eq("idle_in_play", in_play, 0);

    // Serve then three plain frames
    run_cycle(0, 1, 0, 0, 0);
    check_eq("serve_in_play", in_play, 1);
    repeat (3) run_cycle(0, 0, 1, 0, 0);
    check_eq("three_ticks_x", ball_x, 322);
    check_eq("three_ticks_y", ball_y, 242);
    check_eq("three_ticks_in_play", in_play, 1);

    // Bottom wall bounce
    for (int i = 0; i < 300 && m_y != 470; i++) run_cycle(0, 0, 1, 0, 0);
    check_eq("wall_pre_y", ball_y, 470);
    run_cycle(0, 0, 1, 0, 0);
    check_eq("wall_hit_y", ball_y, 472);
    run_cycle(0, 0, 1, 0, 0);
    check_eq("wall_back_y", ball_y, 470);

    // Asynchronous reset between edges, serve held through reset
    #1 reset = 1'b1; serve = 1'b1;
    #1;
    check_eq("async_rst_x", ball_x, 316);
    check_eq("async_rst_y", ball_y, 236);
    check_eq("async_rst_in_play", in_play, 0);
    model_reset();
    run_cycle(1, 1, 0, 0, 0);
    run_cycle(0, 1, 0, 0, 0);
    check_eq("serve_after_rst", in_play, 1);

    // Let the ball run out on the right: left player scores
    for (int i = 0; i < 400 && !m_pl; i++) run_cycle(0, 0, 1, 0, 0);
    check_eq("score_l_pulse", point_l, 1);
    check_eq("score_l_x", ball_x, 632);
    for (int i = 0; i < 100 && m_mode != 0; i++) run_cycle(0, 0, 1, 0, 0);

    // Serve goes left now; a right-paddle hit while moving left is ignored
    run_cycle(0, 1, 0, 0, 0);
    run_cycle(0, 0, 1, 0, 1);
    check_eq("wrong_side_hit_x", ball_x, 314);
    for (int i = 0; i < 300 && m_x != 102; i++) run_cycle(0, 0, 1, 0, 0);
    run_cycle(0, 0, 1, 1, 0);
    check_eq("hit_l_x", ball_x, 105);
    run_cycle(0, 0, 1, 0, 1);
    check_eq("hit_r_x", ball_x, 101);
    for (int i = 0; i < 100 && m_x != 1; i++) run_cycle(0, 0, 1, 0, 0);
    check_eq("edge_x", ball_x, 1);

    // Miss on the left: right player scores, hold, re-centre
    run_cycle(0, 0, 1, 0, 0);
    check_eq("miss_x", ball_x, 0);
    check_eq("miss_point_r", point_r, 1);
    run_cycle(0, 1, 0, 0, 0);
    check_eq("scored_serve_ignored", in_play, 0);
    check_eq("scored_point_r_drop", point_r, 0);
    repeat (HOLD - 1) run_cycle(0, 0, 1, 0, 0);
    check_eq("hold_frozen_x", ball_x, 0);
    run_cycle(0, 0, 1, 0, 0);
    check_eq("recentre_x", ball_x, 316);
    check_eq("recentre_y", ball_y, 236);
    run_cycle(0, 1, 0, 0, 0);
    run_cycle(0, 0, 1, 0, 0);
    check_eq("serve_right_x", ball_x, 318);

    // Alternate paddle returns until the speed saturates
    for (int k = 0; k < 8; k++) begin
      run_cycle(0, 0, 1, (m_xdir < 0), (m_xdir > 0));
      repeat (2) run_cycle(0, 0, 1, 0, 0);
    end
    check_eq("saturate_x", ball_x, 327);

    // Random play
    for (int i = 0; i < 15000; i++) begin
      bit r, s, t, hl, hr;
      int p;
      r = ($urandom_range(0, 2999) == 0);
      s = ($urandom_range(0, 15) == 0);
      t = $urandom_range(0, 1);
      p = (m_mode == 1 && (m_x < 40 || m_x > XMAX - 40)) ? 3 : 40;
      hl = ($urandom_range(0, p - 1) == 0);
      hr = ($urandom_range(0, p - 1) == 0);
      run_cycle(r, s, t, hl, hr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
